// File: rtl/ram_pkg.sv
// ram_pkg: shared word/address sizes and the controller state encoding for the
// 16x8 single-port RAM slice. Both ram_mem and ram_access_ctrl import this.
package ram_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   // Controller states. ST_VERIFY is only entered when RAM_VERIFY_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_FIN     = 3'd4,
      ST_VERIFY  = 3'd5
   } state_t;

endpackage

// File: rtl/ram_burst_cnt.sv
// ram_burst_cnt: burst address generator for ram_access_ctrl. Holds the current
// RAM address (wrapping modulo the RAM depth), the beat counter and the burst
// length, and flags the last beat of the burst.
module ram_burst_cnt #(
   parameter int ADDR_W = ram_pkg::ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_start,
   input  logic [ADDR_W-1:0] i_len,
   output logic [ADDR_W-1:0] o_cur,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_cur;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_len;

   // Load start/length on an accepted request, advance address and beat count
   // at the end of each beat; the address simply overflows to wrap around.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur <= '0;
         r_cnt <= '0;
         r_len <= '0;
      end else if (i_load) begin
         r_cur <= i_start;
         r_cnt <= '0;
         r_len <= i_len;
      end else if (i_step) begin
         r_cur <= r_cur + 1'b1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cur  = r_cur;
   assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: requester-side burst controller for the 16x8 single-port RAM.
// Accepts single/burst read and write requests over REQ/BUSY/DONE, drives the
// RAM CE/ADDR/DIN pins and returns read beats with an RVALID strobe.
// Optional build macro RAM_VERIFY_EN: every write beat is read back and compared;
// a mismatch raises the sticky ERR flag. Without it ERR is tied low.
module ram_access_ctrl #(
   parameter int DATA_W   = ram_pkg::DATA_W,
   parameter int ADDR_W   = ram_pkg::ADDR_W,
   parameter int READ_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ADDR_W-1:0] i_len,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_wnext,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_ram_ce,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_din,
   input  logic [DATA_W-1:0] i_ram_dout
);

   import ram_pkg::*;

   // Wait-counter preloads: RD_WAIT lasts READ_LAT cycles, VERIFY lasts 1+READ_LAT.
   localparam logic [1:0] WAIT_INIT = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);
`ifdef RAM_VERIFY_EN
   localparam logic [1:0] LAT_CNT   = 2'(READ_LAT);
`endif

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_rvalid;
   logic              r_wnext;
   logic              r_ram_ce;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_wait;
`ifdef RAM_VERIFY_EN
   logic              r_err;
   logic [DATA_W-1:0] r_wword;
`endif

   logic              w_load;
   logic              w_step;
   logic              w_last;
   logic [ADDR_W-1:0] w_cur;

   ram_burst_cnt #(
      .ADDR_W (ADDR_W)
   ) u_burst_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_start (i_addr),
      .i_len   (i_len),
      .o_cur   (w_cur),
      .o_last  (w_last)
   );

   // Counter control: load on an accepted request, step on the final cycle of a beat.
   always_comb begin
      w_load = (r_state == ST_IDLE) && i_req;
      w_step = 1'b0;
      case (r_state)
`ifdef RAM_VERIFY_EN
         ST_VERIFY:  w_step = (r_wait == 2'd0);
`else
         ST_WR:      w_step = 1'b1;
`endif
         ST_RD_ADDR: w_step = (READ_LAT == 0);
         ST_RD_WAIT: w_step = (r_wait == 2'd0);
         default:    w_step = 1'b0;
      endcase
   end

   // Main FSM with registered handshake and RAM-control outputs; strobes default low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rvalid <= 1'b0;
         r_wnext  <= 1'b0;
         r_ram_ce <= 1'b0;
         r_rdata  <= '0;
         r_wait   <= '0;
`ifdef RAM_VERIFY_EN
         r_err    <= 1'b0;
         r_wword  <= '0;
`endif
      end else begin
         r_done   <= 1'b0;
         r_rvalid <= 1'b0;
         r_wnext  <= 1'b0;
         r_ram_ce <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req) begin
                  r_busy <= 1'b1;
`ifdef RAM_VERIFY_EN
                  r_err  <= 1'b0;
`endif
                  if (i_we) begin
                     r_state  <= ST_WR;
                     r_ram_ce <= 1'b1;
                     r_wnext  <= 1'b1;
                  end else begin
                     r_state <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR: begin
`ifdef RAM_VERIFY_EN
               r_wword <= i_wdata;
               r_wait  <= LAT_CNT;
               r_state <= ST_VERIFY;
`else
               if (w_last) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_ram_ce <= 1'b1;
                  r_wnext  <= 1'b1;
               end
`endif
            end
`ifdef RAM_VERIFY_EN
            ST_VERIFY: begin
               if (r_wait == 2'd0) begin
                  if (i_ram_dout != r_wword) begin
                     r_err <= 1'b1;
                  end
                  if (w_last) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= ST_WR;
                     r_ram_ce <= 1'b1;
                     r_wnext  <= 1'b1;
                  end
               end else begin
                  r_wait <= r_wait - 2'd1;
               end
            end
`endif
            ST_RD_ADDR: begin
               if (READ_LAT == 0) begin
                  r_rdata  <= i_ram_dout;
                  r_rvalid <= 1'b1;
                  if (w_last) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_wait  <= WAIT_INIT;
                  r_state <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (r_wait == 2'd0) begin
                  r_rdata  <= i_ram_dout;
                  r_rvalid <= 1'b1;
                  if (w_last) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RD_ADDR;
                  end
               end else begin
                  r_wait <= r_wait - 2'd1;
               end
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_wnext    = r_wnext;
   assign o_rdata    = r_rdata;
   assign o_rvalid   = r_rvalid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_ram_ce   = r_ram_ce;
   assign o_ram_addr = w_cur;
   assign o_ram_din  = r_ram_ce ? i_wdata : '0;
`ifdef RAM_VERIFY_EN
   assign o_err      = r_err;
`else
   assign o_err      = 1'b0;
`endif

endmodule
